// File: rtl/freq_pkg.sv
// Types and constants shared by the frequency counter and the downstream BCD stage.
package freq_pkg;

  localparam int unsigned BIN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } freq_state_e;

endpackage

// File: rtl/freq_gate_counter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// rising-edge strobe; strobe appears SYNC_STAGES+1 cycles after the input edge.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks and latches
// the result into bin. Define FREQ_OVF_SAT_EN for saturating count with an overflow flag.
module freq_gate_counter
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [BIN_W-1:0] bin,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned        TIMER_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

  freq_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BIN_W-1:0]   count_q, count_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic               valid_q, valid_d;
  logic               rise;

`ifdef FREQ_OVF_SAT_EN
  logic wovf_q, wovf_d;
  logic ovf_q,  ovf_d;
`endif

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
`ifdef FREQ_OVF_SAT_EN
    wovf_d  = wovf_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        count_d = '0;
`ifdef FREQ_OVF_SAT_EN
        wovf_d  = 1'b0;
`endif
        if (en) state_d = GATE;
      end
      GATE: begin
        if (!en) begin
          state_d = IDLE;
          timer_d = '0;
          count_d = '0;
`ifdef FREQ_OVF_SAT_EN
          wovf_d  = 1'b0;
`endif
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          if (rise) begin
`ifdef FREQ_OVF_SAT_EN
            if (count_q == '1) wovf_d  = 1'b1;
            else               count_d = count_q + BIN_W'(1);
`else
            count_d = count_q + BIN_W'(1);
`endif
          end
          if (timer_q == TIMER_LAST) begin
            state_d = LATCH;
            timer_d = '0;
          end
        end
      end
      LATCH: begin
        bin_d   = count_q;
        valid_d = 1'b1;
        timer_d = '0;
        // An edge landing on the latch cycle belongs to the next window.
        count_d = rise ? BIN_W'(1) : '0;
`ifdef FREQ_OVF_SAT_EN
        ovf_d   = wovf_q;
        wovf_d  = 1'b0;
`endif
        state_d = en ? GATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
`ifdef FREQ_OVF_SAT_EN
      wovf_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
`ifdef FREQ_OVF_SAT_EN
      wovf_q  <= wovf_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bin   = bin_q;
  assign valid = valid_q;
`ifdef FREQ_OVF_SAT_EN
  assign ovf   = ovf_q;
`else
  assign ovf   = 1'b0;
`endif

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000000: gate window length in clk cycles (minimum 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sig_in (minimum 2).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  measurement enable; low holds the block idle.
REQ-006 SHALL have port sig_in  input  1  measured signal, asynchronous to clk.
REQ-007 SHALL have port bin  output  8  edge count of the last completed window; this is the binary input of the downstream BCD converter.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when bin updates.
REQ-009 SHALL have port ovf  output  1  the last completed window exceeded 255 edges.

Function
REQ-010 SHALL pass sig_in through SYNC_STAGES flops, then detect rising edges (previous 0, current 1) as a one-cycle edge strobe.
REQ-011 SHALL implement FSM states IDLE, GATE and LATCH.
REQ-012 IDLE: timer=0, count=0; when en=1, go to GATE next cycle.
REQ-013 GATE: timer increments each cycle; each edge strobe increments count; when timer==GATE_CYCLES-1, go to LATCH next cycle.
REQ-014 An edge strobe on the cycle timer==GATE_CYCLES-1 SHALL be counted in the current window.
REQ-015 LATCH, single cycle: bin<=count, valid<=1, timer<=0, count<=(edge strobe this cycle ? 1 : 0); next state GATE, or IDLE if en=0.
REQ-016 valid SHALL be high for exactly one cycle per completed window and low otherwise.
REQ-017 en=0 in GATE SHALL abort: next state IDLE, timer and count cleared, no valid, bin and ovf retain their values.
REQ-018 The synchronizer and edge detector SHALL run regardless of en, so re-enabling cannot create a false edge.
REQ-019 Latency: a sig_in rising edge SHALL produce its strobe SYNC_STAGES+1 cycles later; bin SHALL update one cycle after the final gate cycle.
REQ-020 The internal count SHALL be 8 bits; timer width SHALL be $clog2(GATE_CYCLES).

Reset
REQ-021 With rst_n low, the block SHALL immediately set bin=0, valid=0, ovf=0, FSM=IDLE, and clear timer, count, sync flops and edge history.
REQ-022 Reset asserted mid-window SHALL discard that window; after release, counting SHALL resume from IDLE per REQ-012.

Configuration
REQ-023 With macro FREQ_OVF_SAT_EN defined: count SHALL saturate at 255; a sticky window-overflow bit SHALL be set on any increment attempted at 255; at LATCH, ovf<=that bit, then the bit is cleared.
REQ-024 Without FREQ_OVF_SAT_EN: count SHALL wrap modulo 256, and ovf SHALL be constant 0.

Structure
REQ-025 Package freq_pkg SHALL hold the FSM state enum (IDLE/GATE/LATCH) and constant BIN_W=8, shared with the BCD stage.
REQ-026 Sub-module sync_edge (parameter SYNC_STAGES; ports clk, rst_n, d, rise) SHALL implement REQ-010 and REQ-018.

Verification (GATE_CYCLES=100 unless stated)
REQ-027 Release reset, en=1, 10 sig_in rising edges at 8-clk spacing inside the window -> one valid pulse, bin=10, ovf=0.
REQ-028 GATE_CYCLES=1000, sig_in period 2 clk (500 edges) -> with FREQ_OVF_SAT_EN: bin=255, ovf=1; without: bin=244, ovf=0.
REQ-029 First window completes with bin=7; en dropped at cycle 50 of the second window -> no valid pulse, bin stays 7; en re-raised -> next valid pulse arrives 101 cycles after GATE re-entry.
REQ-030 Strobe forced on the last gate cycle and on the LATCH cycle -> the first counts in window N; window N+1 starts at count=1.
REQ-031 rst_n pulsed low mid-window with bin=42 -> bin=0, valid=0, ovf=0 before the next clk edge; no valid pulse for the aborted window.
REQ-032 sig_in held constant for a full window -> valid pulse, bin=0, ovf=0.
